// File: rtl/tag_lookup_pipe.sv
// tag_lookup_pipe
//   Lookup / refill / flush controller in front of a SETS x (WAYS*ENTRY_W)
//   tag array. Owns both array ports. A lookup reads one set, compares all
//   ways against the request tag one cycle later, and queues the result in
//   a 2-entry response FIFO. Refills write a single way through the write
//   mask. After reset, and on flush_req, every set is cleared one per cycle.
//
// Ports
//   clock, reset_n              clock, asynchronous active-low reset
//   req_valid/req_ready         lookup handshake; req_set, req_tag
//   resp_valid/resp_ready       response handshake; resp_hit, resp_way,
//                               resp_multi (more than one way matched)
//   fill_valid/fill_ready       refill handshake; fill_set, fill_way, fill_tag
//   flush_req                   pulse: invalidate the whole array
//   busy                        array flush in progress (including drain)
//   arr_r_addr/arr_r_en         array read port, data back next cycle on
//   arr_r_data                  way w at [w*ENTRY_W +: ENTRY_W]
//   arr_w_addr/arr_w_en/        array write port with per-way mask
//   arr_w_data/arr_w_mask
module tag_lookup_pipe #(
    parameter int SETS    = 64,
    parameter int WAYS    = 8,
    parameter int ENTRY_W = 23,
    localparam int SET_W  = $clog2(SETS),
    localparam int WAY_W  = $clog2(WAYS),
    localparam int TAG_W  = ENTRY_W - 1
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [SET_W-1:0]         req_set,
    input  logic [TAG_W-1:0]         req_tag,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic                     resp_hit,
    output logic [WAY_W-1:0]         resp_way,
    output logic                     resp_multi,
    input  logic                     fill_valid,
    output logic                     fill_ready,
    input  logic [SET_W-1:0]         fill_set,
    input  logic [WAY_W-1:0]         fill_way,
    input  logic [TAG_W-1:0]         fill_tag,
    input  logic                     flush_req,
    output logic                     busy,
    output logic [SET_W-1:0]         arr_r_addr,
    output logic                     arr_r_en,
    input  logic [WAYS*ENTRY_W-1:0]  arr_r_data,
    output logic [SET_W-1:0]         arr_w_addr,
    output logic                     arr_w_en,
    output logic [WAYS*ENTRY_W-1:0]  arr_w_data,
    output logic [WAYS-1:0]          arr_w_mask
);

    typedef enum logic [1:0] {FLUSH, RUN, DRAIN} state_t;

    localparam int RES_W = WAY_W + 2;  // {hit, way, multi}

    state_t              state, state_nxt;
    logic [SET_W-1:0]    flush_cnt;
    logic                fill_bubble;
    logic                vld_p1;
    logic [TAG_W-1:0]    tag_p1;
    logic [RES_W-1:0]    fifo_mem [2];
    logic                fifo_rd_ptr, fifo_wr_ptr;
    logic [1:0]          fifo_cnt;

    logic                run, fill_acc, req_acc, deq;
    logic [2:0]          occ_after;
    logic [WAYS-1:0]     hit_vec_p1;
    logic [RES_W-1:0]    res_p1;

    function automatic logic [WAY_W-1:0] lowest_way(input logic [WAYS-1:0] v);
        lowest_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (v[w]) lowest_way = WAY_W'(w);
        end
    endfunction

    // More than one bit set: clearing the lowest set bit leaves something.
    function automatic logic multi_hit(input logic [WAYS-1:0] v);
        multi_hit = (v & (v - WAYS'(1))) != '0;
    endfunction

    // ---- S0: handshake decisions, array read issue ----
    always_comb begin
        run        = (state == RUN);
        fill_ready = run & ~flush_req;
        fill_acc   = fill_valid & fill_ready;
        deq        = resp_valid & resp_ready;
        // Occupancy after this cycle's dequeue; a new lookup may enter only
        // if it is guaranteed a FIFO slot when it leaves S1.
        occ_after  = 3'({2'b00, vld_p1}) + 3'({1'b0, fifo_cnt}) - 3'({2'b00, deq});
        req_ready  = run & ~fill_valid & ~fill_bubble & (occ_after < 3'd2);
        req_acc    = req_valid & req_ready;
        arr_r_en   = req_acc;
        arr_r_addr = req_set;
        busy       = ~run;
    end

    // Write port: flush sweep while in FLUSH, otherwise the refill path.
    // Writes are held off while reset is asserted.
    always_comb begin
        arr_w_en   = 1'b0;
        arr_w_addr = fill_set;
        arr_w_data = {WAYS{1'b1, fill_tag}};
        arr_w_mask = WAYS'(1) << fill_way;
        if (state == FLUSH) begin
            arr_w_en   = reset_n;
            arr_w_addr = flush_cnt;
            arr_w_data = '0;
            arr_w_mask = '1;
        end else begin
            arr_w_en   = fill_acc;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FLUSH:   if (flush_cnt == SET_W'(SETS - 1)) state_nxt = RUN;
            RUN:     if (flush_req) state_nxt = DRAIN;
            DRAIN:   if (!vld_p1) state_nxt = FLUSH;
            default: state_nxt = FLUSH;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= FLUSH;
            flush_cnt   <= '0;
            fill_bubble <= 1'b0;
            vld_p1      <= 1'b0;
        end else begin
            state       <= state_nxt;
            flush_cnt   <= (state == FLUSH && flush_cnt != SET_W'(SETS - 1))
                           ? flush_cnt + SET_W'(1) : '0;
            fill_bubble <= fill_acc;
            vld_p1      <= req_acc;
        end
    end

    always_ff @(posedge clock) begin
        if (req_acc) tag_p1 <= req_tag;
    end

    // ---- S1: tag compare against returned set, push result ----
    always_comb begin
        for (int w = 0; w < WAYS; w++) begin
            hit_vec_p1[w] = arr_r_data[w*ENTRY_W + TAG_W]
                          && (arr_r_data[w*ENTRY_W +: TAG_W] == tag_p1);
        end
        res_p1 = {(hit_vec_p1 != '0), lowest_way(hit_vec_p1), multi_hit(hit_vec_p1)};
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fifo_rd_ptr <= 1'b0;
            fifo_wr_ptr <= 1'b0;
            fifo_cnt    <= '0;
        end else begin
            if (vld_p1) fifo_wr_ptr <= ~fifo_wr_ptr;
            if (deq)    fifo_rd_ptr <= ~fifo_rd_ptr;
            fifo_cnt <= fifo_cnt + 2'(vld_p1) - 2'(deq);
        end
    end

    always_ff @(posedge clock) begin
        if (vld_p1) fifo_mem[fifo_wr_ptr] <= res_p1;
    end

    // ---- Response FIFO head ----
    always_comb begin
        resp_valid = (fifo_cnt != '0);
        {resp_hit, resp_way, resp_multi} = fifo_mem[fifo_rd_ptr];
    end

endmodule
